// File: rtl/bootload_pkg.sv
// Shared definitions for the instruction boot loader: FSM state encoding and image field sizes.
package bootload_pkg;
  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    COLLECT,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } boot_state_e;

  function automatic logic accepts_bytes(input boot_state_e st);
    return (st == LEN_LO) || (st == LEN_HI) || (st == COLLECT) || (st == CHECK);
  endfunction
endpackage

// File: rtl/boot_word_assembler.sv
// Builds little-endian 32-bit words from image bytes and keeps a running XOR of the image bytes.
module boot_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_en,
  input  logic        xor_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_last,
  output logic [7:0]  xor_sum
);
  // Only the three earlier bytes need storing; the fourth arrives on the completing cycle.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;
  logic [7:0]  xor_q;

  assign word_next = {byte_in, shift_q};
  assign word_last = byte_en && (cnt_q == 2'd3);
  assign xor_sum   = xor_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
    end else begin
      if (byte_en) begin
        shift_q <= {byte_in, shift_q[23:8]};
        cnt_q   <= cnt_q + 2'd1;
      end
      if (xor_en) xor_q <= xor_q ^ byte_in;
    end
  end
endmodule

// File: rtl/instr_boot_loader.sv
// Streams a length-prefixed program image into instruction memory, holding the CPU in reset until done.
// Optional trailing checksum byte is enabled with `define BOOT_CHECKSUM_EN.
module instr_boot_loader
  import bootload_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_WORDS     = 256,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [31:0]           MEM_WRITEDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic                  CPU_RESET,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERROR,
  output logic [8:0]            WORD_COUNT,
  output boot_state_e           DBG_STATE
);
  localparam int DLY_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  if (MAX_WORDS * WORD_BYTES > (1 << ADDR_WIDTH)) begin : g_bad_image_size
    $error("MAX_WORDS words do not fit in instruction memory");
  end
  if (MAX_WORDS > 511 || RELEASE_DELAY < 1) begin : g_bad_params
    $error("MAX_WORDS must fit WORD_COUNT and RELEASE_DELAY must be >= 1");
  end

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e AFTER_IMAGE = CHECK;
`else
  localparam boot_state_e AFTER_IMAGE = DONE;
`endif

  boot_state_e      state_q, state_next;
  logic [LEN_W-1:0] len_q, len_full;
  logic [DLY_W-1:0] dly_q;
  logic [8:0]       count_next;
  logic             rx_accept, write_ack, byte_en, xor_en, word_last;
  logic [31:0]      word_next;
  logic [7:0]       xor_sum;

  // Handshakes: a byte moves on a posedge with RX_VALID && RX_READY; a memory request stays
  // asserted with fixed address/data until a posedge samples MEM_BUSYWAIT low.
  assign rx_accept  = RX_VALID && RX_READY;
  assign byte_en    = rx_accept && (state_q == COLLECT);
  assign xor_en     = rx_accept && (state_q inside {LEN_LO, LEN_HI, COLLECT});
  assign write_ack  = (state_q == WRITE) && MEM_WRITE && !MEM_BUSYWAIT;
  assign count_next = WORD_COUNT + 9'd1;
  assign len_full   = {RX_DATA, len_q[7:0]};
  assign DBG_STATE  = state_q;

  boot_word_assembler u_asm (
    .clk       (CLK),
    .reset     (RESET),
    .byte_en   (byte_en),
    .xor_en    (xor_en),
    .byte_in   (RX_DATA),
    .word_next (word_next),
    .word_last (word_last),
    .xor_sum   (xor_sum)
  );

`ifndef BOOT_CHECKSUM_EN
  logic unused_xor;
  assign unused_xor = ^xor_sum;
`endif

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      LEN_LO:  if (rx_accept) state_next = LEN_HI;
      LEN_HI: begin
        if (rx_accept) begin
          if (len_full > LEN_W'(MAX_WORDS)) state_next = ERROR;
          else if (len_full == '0)          state_next = AFTER_IMAGE;
          else                              state_next = COLLECT;
        end
      end
      COLLECT: if (word_last) state_next = WRITE;
      WRITE: begin
        if (write_ack) state_next = (LEN_W'(count_next) == len_q) ? AFTER_IMAGE : COLLECT;
      end
      CHECK: begin
`ifdef BOOT_CHECKSUM_EN
        if (rx_accept) state_next = (RX_DATA == xor_sum) ? DONE : ERROR;
`endif
      end
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = ERROR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= LEN_LO;
      len_q         <= '0;
      dly_q         <= '0;
      RX_READY      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      CPU_RESET     <= 1'b1;
      LOAD_DONE     <= 1'b0;
      LOAD_ERROR    <= 1'b0;
      WORD_COUNT    <= '0;
    end else begin
      state_q  <= state_next;
      RX_READY <= accepts_bytes(state_next);
      if (state_next == DONE)  LOAD_DONE  <= 1'b1;
      if (state_next == ERROR) LOAD_ERROR <= 1'b1;
      if (rx_accept && state_q == LEN_LO) len_q[7:0] <= RX_DATA;
      if (rx_accept && state_q == LEN_HI) len_q      <= len_full;
      if (word_last) begin
        MEM_WRITE     <= 1'b1;
        MEM_WRITEDATA <= word_next;
      end
      if (write_ack) begin
        MEM_WRITE   <= 1'b0;
        MEM_ADDRESS <= MEM_ADDRESS + ADDR_WIDTH'(WORD_BYTES);
        WORD_COUNT  <= count_next;
      end
      // CPU_RESET drops RELEASE_DELAY edges after the edge that raised LOAD_DONE.
      if (state_q == DONE) begin
        if (dly_q == DLY_W'(RELEASE_DELAY - 1)) CPU_RESET <= 1'b0;
        else                                    dly_q     <= dly_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_boot_loader.sv
// Scoreboard bench for instr_boot_loader: random images, busy memory, gaps, oversize and mid-load reset.
module tb_instr_boot_loader;
  localparam int ADDR_WIDTH    = 10;
  localparam int MAX_WORDS     = 256;
  localparam int RELEASE_DELAY = 4;

  logic                  CLK = 1'b0;
  logic                  RESET = 1'b1;
  logic [7:0]            RX_DATA = '0;
  logic                  RX_VALID = 1'b0;
  logic                  RX_READY;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-1:0] MEM_ADDRESS;
  logic [31:0]           MEM_WRITEDATA;
  logic                  MEM_BUSYWAIT = 1'b0;
  logic                  CPU_RESET;
  logic                  LOAD_DONE;
  logic                  LOAD_ERROR;
  logic [8:0]            WORD_COUNT;
  bootload_pkg::boot_state_e dbg_state;

  instr_boot_loader #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .MAX_WORDS     (MAX_WORDS),
    .RELEASE_DELAY (RELEASE_DELAY)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .RX_DATA       (RX_DATA),
    .RX_VALID      (RX_VALID),
    .RX_READY      (RX_READY),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .CPU_RESET     (CPU_RESET),
    .LOAD_DONE     (LOAD_DONE),
    .LOAD_ERROR    (LOAD_ERROR),
    .WORD_COUNT    (WORD_COUNT),
    .DBG_STATE     (dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int busy_cycles = 0;
  int writes_seen = 0;
  logic [41:0] exp_q[$];          // {byte address, word} of each write the image implies
  logic [31:0] img_words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory side: hold MEM_BUSYWAIT high for busy_cycles cycles of every request.
  initial begin : busy_driver
    int left;
    left = 0;
    forever begin
      @(posedge CLK); #1;
      if (MEM_WRITE && !RESET) begin
        if (left > 0) begin
          MEM_BUSYWAIT = 1'b1;
          left--;
        end else begin
          MEM_BUSYWAIT = 1'b0;
        end
      end else begin
        MEM_BUSYWAIT = 1'b0;
        left = busy_cycles;
      end
    end
  end

  // Monitor: every cycle of a request must match the queue head; it retires when memory is free.
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (!RESET && MEM_WRITE) begin
        chk("rx_ready_during_write", RX_READY, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0h data=%0h required no write", MEM_ADDRESS, MEM_WRITEDATA);
        end else begin
          chk("write_addr", MEM_ADDRESS, exp_q[0][41:32]);
          chk("write_data", MEM_WRITEDATA, exp_q[0][31:0]);
          if (!MEM_BUSYWAIT) void'(exp_q.pop_front());
        end
        if (!MEM_BUSYWAIT) writes_seen++;
      end
    end
  end

  task automatic do_reset();
    exp_q.delete();
    RESET = 1'b1;
    RX_VALID = 1'b0;
    busy_cycles = 0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_rx_ready", RX_READY, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    chk("rst_mem_address", MEM_ADDRESS, 0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 0);
    chk("rst_cpu_reset", CPU_RESET, 1);
    chk("rst_load_done", LOAD_DONE, 0);
    chk("rst_load_error", LOAD_ERROR, 0);
    chk("rst_word_count", WORD_COUNT, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin @(posedge CLK); #1; end
    RX_DATA = b;
    RX_VALID = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge CLK);
      ok = RX_READY;
      @(posedge CLK); #1;
    end
    RX_VALID = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL rx_accept_timeout byte=%0h not accepted, required acceptance within 200 cycles", b);
    end
  endtask

  // Streams LEN, the little-endian words of img_words and (when enabled) the XOR checksum.
  // byte_limit >= 0 stops after that many data bytes.
  task automatic send_image(input int len, input int gap, input int byte_limit, input bit bad_cks);
    logic [7:0] cks;
    logic [7:0] b;
    int sent;
    cks = len[7:0] ^ len[15:8];
    sent = 0;
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    if (len > MAX_WORDS) return;
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (byte_limit >= 0 && sent >= byte_limit) return;
        b = 8'(img_words[i] >> (8 * j));
        cks ^= b;
        if (j == 3) exp_q.push_back({10'(4 * i), img_words[i]});
        send_byte(b, gap);
        sent++;
      end
    end
`ifdef BOOT_CHECKSUM_EN
    if (byte_limit < 0) send_byte(bad_cks ? ~cks : cks, gap);
`else
    if (bad_cks) $display("note: checksum byte not part of this build");
`endif
  endtask

  task automatic expect_done(input int len);
    int t = 0;
    int cnt = 0;
    @(negedge CLK);
    while (!LOAD_DONE && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk("load_done", LOAD_DONE, 1);
    if (LOAD_DONE) begin
      chk("writes_acked_before_done", exp_q.size(), 0);
      chk("word_count", WORD_COUNT, len);
      chk("no_error_on_good_image", LOAD_ERROR, 0);
      if (len < MAX_WORDS) chk("final_address", MEM_ADDRESS, 4 * len);
      while (CPU_RESET && cnt < 20) begin
        cnt++;
        @(negedge CLK);
      end
      chk("release_delay", cnt, RELEASE_DELAY);
      repeat (3) @(negedge CLK);
      chk("cpu_released", CPU_RESET, 0);
      chk("done_sticky", LOAD_DONE, 1);
    end
    @(posedge CLK); #1;
  endtask

  task automatic expect_error(input int exp_writes);
    @(negedge CLK);
    chk("load_error", LOAD_ERROR, 1);
    chk("error_state", dbg_state, bootload_pkg::ERROR);
    chk("error_no_done", LOAD_DONE, 0);
    RX_VALID = 1'b1;
    RX_DATA = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("error_rx_ready", RX_READY, 0);
    end
    RX_VALID = 1'b0;
    chk("error_cpu_reset_held", CPU_RESET, 1);
    chk("error_write_count", writes_seen, exp_writes);
    @(posedge CLK); #1;
  endtask

  initial begin : stimulus
    int ws;
    int len;
    do_reset();

    img_words = '{32'h0200_0000, 32'h4000_0100};
    send_image(2, 0, -1, 0);
    expect_done(2);
    do_reset();

    busy_cycles = 3;
    send_image(2, 0, -1, 0);
    expect_done(2);
    do_reset();

    img_words = '{32'h0200_0000, 32'h4000_0100};
    send_image(2, 1, -1, 0);
    expect_done(2);
    do_reset();

    ws = writes_seen;
    send_image(16'h0101, 0, -1, 0);
    expect_error(ws);
    do_reset();

    img_words = '{32'($urandom), 32'($urandom), 32'($urandom)};
    ws = writes_seen;
    send_image(3, 0, 6, 0);
    chk("words_before_midload_reset", writes_seen - ws, 1);
    chk("count_before_midload_reset", WORD_COUNT, 1);
    do_reset();
    send_image(3, 0, -1, 0);
    expect_done(3);
    do_reset();

    img_words.delete();
    send_image(0, 0, -1, 0);
    expect_done(0);
    do_reset();

    img_words.delete();
    for (int i = 0; i < MAX_WORDS; i++) img_words.push_back($urandom);
    send_image(MAX_WORDS, 0, -1, 0);
    expect_done(MAX_WORDS);
    do_reset();

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 6);
      img_words.delete();
      for (int i = 0; i < len; i++) img_words.push_back($urandom);
      busy_cycles = $urandom_range(0, 3);
      send_image(len, $urandom_range(0, 2), -1, 0);
      expect_done(len);
      do_reset();
    end

`ifdef BOOT_CHECKSUM_EN
    img_words = '{32'h0200_0000, 32'h4000_0100};
    ws = writes_seen;
    send_image(2, 0, -1, 1);
    expect_error(ws + 2);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
